// File: rtl/vz_pkg.sv
// vz_pkg: shared state encoding, header constants and FIFO entry type for the VZ image loader.
package vz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } vz_state_e;

  localparam logic [15:0] VZ_HDR_LEN    = 16'd24;
  localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_MC    = 8'hF1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } vz_entry_t;

  // Magic bytes: alt=0 selects "VZF0", alt=1 selects the "  \0\0" variant.
  function automatic logic [7:0] vz_magic_byte(input logic alt, input logic [1:0] idx);
    logic [7:0] b;
    if (alt) begin
      b = (idx < 2'd2) ? 8'h20 : 8'h00;
    end else begin
      case (idx)
        2'd0:    b = 8'h56;
        2'd1:    b = 8'h5A;
        2'd2:    b = 8'h46;
        default: b = 8'h30;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/vz_wr_fifo.sv
// vz_wr_fifo: small synchronous FIFO of {addr,data} RAM write entries with flush
// and simultaneous push/pop (a push into a full FIFO succeeds when a pop occurs).
module vz_wr_fifo import vz_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  vz_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output vz_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  vz_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/vz_loader.sv
// vz_loader: parses a VZ image from the ioctl download stream, relocates the payload into RAM
// and patches the BASIC/USR entry pointers. Optional macro VZ_MAGIC_CHECK_EN enables the magic-byte check.
module vz_loader import vz_pkg::*; #(
  parameter logic [7:0]  VZ_INDEX        = 8'd1,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] BASIC_START_PTR = 16'h78A4,
  parameter logic [15:0] BASIC_END_PTR   = 16'h78F9,
  parameter logic [15:0] USR_PTR         = 16'h788E
) (
  input  logic        CLK10MHZ,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic [7:0]  dn_index,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        ram_req,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  vz_type
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_HDR  = ST_HDR;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_FIX  = ST_FIX;
  localparam logic [2:0] S_DONE = ST_DONE;
  localparam logic [2:0] S_ERR  = ST_ERR;

  logic [2:0]  state;
  logic        dl_q;
  logic [15:0] start_addr;
  logic [15:0] count;
  logic [1:0]  fix_idx;
  logic        fix_all;
  logic [7:0]  type_q;
  logic        err_q;

  logic        fifo_full, fifo_empty, fifo_push;
  vz_entry_t   fifo_in, fifo_head, fix_entry;
  logic        idx_ok, load_start, dl_fall, hdr_wr, data_wr, fix_push, type_ok, is_basic;
  logic        magic_fail;
  logic [15:0] data_len, end_addr, fix_base;
  logic [1:0]  fix_last;

  assign idx_ok     = (dn_index == VZ_INDEX);
  assign load_start = dn_download && !dl_q && idx_ok;
  assign dl_fall    = !dn_download && dl_q;
  assign hdr_wr     = dn_wr && idx_ok && (state == S_HDR) && (dn_addr < VZ_HDR_LEN);
  assign data_wr    = dn_wr && idx_ok && (state == S_DATA) && (dn_addr >= VZ_HDR_LEN);
  assign data_len   = dn_addr - (VZ_HDR_LEN - 16'd1);
  assign end_addr   = start_addr + count;
  assign is_basic   = (type_q == VZ_TYPE_BASIC);
  assign type_ok    = is_basic || (type_q == VZ_TYPE_MC);
  assign fix_last   = is_basic ? 2'd3 : 2'd1;
  assign fix_base   = is_basic ? BASIC_START_PTR : USR_PTR;
  // A pointer byte may enter a full FIFO only when the head is leaving in the same cycle.
  assign fix_push   = (state == S_FIX) && !fix_all && (!fifo_full || ram_ack);

  always_comb begin
    fix_entry = '0;
    case (fix_idx)
      2'd0:    begin fix_entry.addr = fix_base;              fix_entry.data = start_addr[7:0];  end
      2'd1:    begin fix_entry.addr = fix_base + 16'd1;      fix_entry.data = start_addr[15:8]; end
      2'd2:    begin fix_entry.addr = BASIC_END_PTR;         fix_entry.data = end_addr[7:0];    end
      default: begin fix_entry.addr = BASIC_END_PTR + 16'd1; fix_entry.data = end_addr[15:8];   end
    endcase
  end

  always_comb begin
    fifo_in      = '0;
    fifo_push    = data_wr || fix_push;
    fifo_in.addr = start_addr + (dn_addr - VZ_HDR_LEN);
    fifo_in.data = dn_data;
    if (state == S_FIX) fifo_in = fix_entry;
  end

`ifdef VZ_MAGIC_CHECK_EN
  logic magic_a, magic_b, hit_a, hit_b;
  assign hit_a      = magic_a && (dn_data == vz_magic_byte(1'b0, dn_addr[1:0]));
  assign hit_b      = magic_b && (dn_data == vz_magic_byte(1'b1, dn_addr[1:0]));
  assign magic_fail = hdr_wr && (dn_addr == 16'd3) && !hit_a && !hit_b;

  always_ff @(posedge CLK10MHZ or negedge RESET) begin
    if (!RESET) begin
      magic_a <= 1'b1;
      magic_b <= 1'b1;
    end else if (load_start) begin
      magic_a <= 1'b1;
      magic_b <= 1'b1;
    end else if (hdr_wr && (dn_addr < 16'd4)) begin
      magic_a <= hit_a;
      magic_b <= hit_b;
    end
  end
`else
  assign magic_fail = 1'b0;
`endif

  always_ff @(posedge CLK10MHZ or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      start_addr <= '0;
      count      <= '0;
      fix_idx    <= '0;
      fix_all    <= 1'b0;
      type_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      dl_q <= dn_download;
      if (load_start) begin
        state   <= S_HDR;
        err_q   <= 1'b0;
        count   <= '0;
        fix_idx <= '0;
        fix_all <= 1'b0;
      end else begin
        if (data_wr && fifo_full && !ram_ack) err_q <= 1'b1;
        if (data_wr && (data_len > count)) count <= data_len;
        case (state)
          S_HDR: begin
            if (dl_fall || magic_fail) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else if (hdr_wr) begin
              if (dn_addr == 16'd21) type_q <= dn_data;
              if (dn_addr == 16'd22) start_addr[7:0] <= dn_data;
              if (dn_addr == 16'd23) begin
                start_addr[15:8] <= dn_data;
                state            <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (dl_fall) begin
              if (type_ok) begin
                state <= S_FIX;
              end else begin
                state <= S_ERR;
                err_q <= 1'b1;
              end
            end
          end
          S_FIX: begin
            if (fix_push) begin
              if (fix_idx == fix_last) fix_all <= 1'b1;
              else fix_idx <= fix_idx + 2'd1;
            end else if (fix_all && fifo_empty) begin
              state <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  vz_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (CLK10MHZ),
    .rst_n      (RESET),
    .flush      (load_start),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (ram_ack),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // ram_req/ram_ack: an entry is written on a rising edge where both are high;
  // until then ram_req stays high with ram_addr/ram_data held on the head entry.
  assign ram_req  = !fifo_empty;
  assign ram_addr = fifo_empty ? 16'h0000 : fifo_head.addr;
  assign ram_data = fifo_empty ? 8'h00 : fifo_head.data;
  assign busy     = (state == S_HDR) || (state == S_DATA) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign err      = err_q;
  assign vz_type  = type_q;

endmodule

// File: doc/vz_loader.md
Name: vz_loader

Overview:
- Sits between the HPS ioctl download stream (index F1, "Load VZ Image") and the Laser310 system RAM write port.
- Parses the 24-byte VZ header, then relocates the payload bytes to the header start address and writes them to RAM through a small write FIFO.
- After the last byte, patches the BASIC or machine-code entry pointers in system RAM, then reports done or error.

Parameters:
- VZ_INDEX, 8'd1: ioctl_index value that selects VZ downloads; other indices are ignored.
- FIFO_DEPTH, 4: RAM write FIFO entries; power of two, minimum 2.
- BASIC_START_PTR, 16'h78A4: RAM address of the BASIC program start pointer (2 bytes, little-endian).
- BASIC_END_PTR, 16'h78F9: RAM address of the BASIC program end pointer (2 bytes, little-endian).
- USR_PTR, 16'h788E: RAM address of the machine-code USR vector (2 bytes, little-endian).

Ports:
- CLK10MHZ, in, 1: system clock; all logic on the rising edge.
- RESET, in, 1: asynchronous, active-low reset.
- dn_download, in, 1: download active level.
- dn_index, in, 8: download slot.
- dn_wr, in, 1: one-cycle byte strobe.
- dn_addr, in, 16: byte offset in the file.
- dn_data, in, 8: byte value.
- ram_req, out, 1: RAM write request, held until acked.
- ram_addr, out, 16: RAM write address.
- ram_data, out, 8: RAM write data.
- ram_ack, in, 1: write accepted this cycle.
- busy, out, 1: high from load start until DONE or ERR.
- done, out, 1: one-cycle pulse on successful completion.
- err, out, 1: sticky error flag; cleared at the next load start.
- vz_type, out, 8: captured header type byte.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; start address and byte count cleared.
- Load start: a rising edge of dn_download while dn_index==VZ_INDEX.
  - Flushes the FIFO, clears err, enters HDR.
  - Also applies mid-load: any state restarts cleanly from HDR.
- HDR:
  - dn_wr with dn_addr 0..23 captures bytes.
  - Byte 21 goes to vz_type.
  - Bytes 22/23 go to start[7:0] / start[15:8].
  - Bytes 0..20 are ignored unless the optional feature is compiled in.
  - Once byte 23 is captured, enter DATA.
- DATA:
  - dn_wr with dn_addr>=24 pushes {start + (dn_addr-24), dn_data} into the FIFO.
  - Address arithmetic is 16-bit modulo; 0xFFFF+1 wraps to 0x0000.
  - count = max(count, dn_addr-23), so end = start + count (mod 2^16).
- Falling edge of dn_download:
  - From HDR: go to ERR (short file).
  - From DATA: go to FIX.
  - Also go to ERR if vz_type is not F0 or F1.
- FIX:
  - Pushes pointer bytes into the FIFO, low byte first.
  - F0: start to BASIC_START_PTR/+1, end to BASIC_END_PTR/+1 (4 bytes).
  - F1: start to USR_PTR/+1 (2 bytes).
  - Stalls while the FIFO is full.
  - When all pointer bytes are pushed and the FIFO has drained, go to DONE.
- DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- ERR: set err, drop busy, return to IDLE. The FIFO still drains any entries already queued.
- FIFO/RAM port:
  - ram_req = !empty; ram_addr/ram_data show the head entry.
  - Pop on ram_req && ram_ack.
  - Push and pop in the same cycle are both honoured, including when full.
  - dn_wr while full and no pop: byte dropped, err set; the load still continues to FIX.
  - Worst-case latency from dn_wr to ram_req is 1 cycle (registered FIFO output).
- Ignored inputs:
  - dn_wr when dn_index!=VZ_INDEX or the FSM is in IDLE.
  - dn_wr when dn_addr<24 while in DATA (no effect).

Optional Feature:
- Macro: VZ_MAGIC_CHECK_EN.
- Defined: HDR compares bytes 0..3 against "VZF0" or "  \0\0" (0x20,0x20,0x00,0x00). On mismatch the FSM enters ERR at byte 3, and later dn_wr are ignored until the next load start.
- Undefined: magic bytes are ignored and no compare logic is synthesized.

Decomposition:
- Package vz_pkg: FSM state enum (IDLE, HDR, DATA, FIX, DONE, ERR), VZ_HDR_LEN=24, VZ_TYPE_BASIC=8'hF0, VZ_TYPE_MC=8'hF1, and the FIFO entry struct {addr[15:0], data[7:0]}.
- Sub-module vz_wr_fifo: synchronous FIFO of FIFO_DEPTH 24-bit entries with full/empty, flush, and simultaneous push/pop.

Test Plan:
- BASIC load: F0 file, start=0x7AE9, 5 payload bytes, ram_ack always 1.
  - RAM gets 0x7AE9..0x7AED in order.
  - Then 0x78A4=E9, 0x78A5=7A, 0x78F9=EE, 0x78FA=7A.
  - done pulses once; err=0.
- MC load with backpressure: F1 file, start=0x8000, 3 bytes, ram_ack high every 4th cycle.
  - All 3 writes, then 0x788E=00, 0x788F=80.
  - No drops; busy stays high until done.
- Overflow: FIFO_DEPTH=4, ram_ack held 0, 6 back-to-back payload strobes.
  - 4 entries kept, err=1.
  - Once ram_ack is released, the queued entries plus pointer patch drain.
  - No done pulse is required.
- Short file: download ends after 10 bytes.
  - ERR, err=1, no RAM writes, done never pulses.
- Wrap and restart: start=0xFFFE, 4 bytes.
  - Writes go to FFFE, FFFF, 0000, 0001.
  - A new rising edge of dn_download mid-DATA flushes the FIFO, clears err, and the second file loads correctly.
- Reset mid-DATA: RESET low asynchronously.
  - Outputs go to 0 immediately.
  - After release, the FSM is in IDLE and stray dn_wr are ignored.
